// File: rtl/dsss_spreader_pkg.sv
// ---------------------------------------------------------------------------
// dsss_pkg -- shared definitions for the DSSS spreader and its receiver-side
// counterpart.
//
// Contents:
//   PN_LEN / PN_LAST   length of the 63-chip m-sequence and its last index
//   PN_LAST_IDX        PN_LAST as a 6-bit chip-index value
//   DEFAULT_SEED       LFSR state at chip index 0
//   TAP_HI / TAP_LO    Fibonacci taps for x^6 + x^5 + 1 (output is TAP_HI)
//   state_t            spreader FSM states (IDLE, RUN)
//   lfsr_step()        one shift of the 6-stage Fibonacci LFSR
// ---------------------------------------------------------------------------
package dsss_pkg;

    localparam int         PN_LEN       = 63;
    localparam int         PN_LAST      = 62;
    localparam logic [5:0] PN_LAST_IDX  = 6'(PN_LAST);
    localparam logic [5:0] DEFAULT_SEED = 6'b111111;

    // x^6 + x^5 + 1: output is stage 5, feedback is stage 5 XOR stage 4.
    localparam int TAP_HI = 5;
    localparam int TAP_LO = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Shift left and insert the feedback bit at stage 0.
    function automatic logic [5:0] lfsr_step(input logic [5:0] s);
        return {s[4:0], s[TAP_HI] ^ s[TAP_LO]};
    endfunction

endpackage

// File: rtl/dsss_spreader_if.sv
// ---------------------------------------------------------------------------
// dsss_spreader_if -- data handshake and chip stream of the DSSS spreader.
//
// Signals:
//   en         transmit enable (level)
//   din        data bit to spread
//   din_valid  din is valid
//   din_ready  spreader accepts din this cycle
//   chip_out   spread chip (registered)
//   chip_stb   one-clk strobe: chip_out / pn_addr valid
//   pn_addr    chip index within the PN period, 0..62
//   sym_start  high with the chip_stb of pn_addr == 0
//   underrun   sticky: a symbol boundary found no data
//   busy       spreader is in RUN
//
// Modports:
//   master  data source / chip consumer side
//   slave   the spreader itself
// ---------------------------------------------------------------------------
interface dsss_spreader_if;

    logic       en;
    logic       din;
    logic       din_valid;
    logic       din_ready;
    logic       chip_out;
    logic       chip_stb;
    logic [7:0] pn_addr;
    logic       sym_start;
    logic       underrun;
    logic       busy;

    modport master (
        output en, din, din_valid,
        input  din_ready, chip_out, chip_stb, pn_addr, sym_start, underrun, busy
    );

    modport slave (
        input  en, din, din_valid,
        output din_ready, chip_out, chip_stb, pn_addr, sym_start, underrun, busy
    );

endinterface

// File: rtl/dsss_spreader_pn_gen63.sv
// ---------------------------------------------------------------------------
// pn_gen63 -- 6-stage Fibonacci LFSR producing the 63-chip m-sequence for
// x^6 + x^5 + 1. Shared by the spreader and the receiver PN generator.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-high reset; state returns to SEED
//   load  reload SEED (takes priority over adv)
//   adv   advance one chip
//   code  current PN chip (stage 5)
// ---------------------------------------------------------------------------
module pn_gen63
    import dsss_pkg::*;
#(
    parameter logic [5:0] SEED = DEFAULT_SEED
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic adv,
    output logic code
);

    logic [5:0] lfsr;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (load) begin
            lfsr <= SEED;
        end else if (adv) begin
            lfsr <= lfsr_step(lfsr);
        end
    end

    assign code = lfsr[TAP_HI];

endmodule

// File: rtl/dsss_spreader.sv
// ---------------------------------------------------------------------------
// dsss_spreader -- direct-sequence spreader. Each accepted data bit is XORed
// with one full period (63 chips) of the PN code; each chip lasts DIV clocks.
//
// Parameters:
//   DIV   clk cycles per chip, 2..255
//   SEED  LFSR state at chip index 0 (nonzero)
//
// Ports:
//   clk   system clock
//   rst   asynchronous, active-high reset
//   io    dsss_spreader_if.slave (handshake, chip stream, status)
//
// Operation:
//   IDLE  din_ready = en. A transfer latches the bit, restarts the chip
//         divider and the PN code, and enters RUN.
//   RUN   one chip per DIV clocks. The last chip of a symbol (pn_addr 62)
//         is the only point where new data is taken; without data the
//         symbol repeats the raw PN (sym_bit = 0) and underrun is flagged,
//         and with en low the FSM returns to IDLE after that chip.
//
// Output timing: chip_stb, chip_out, pn_addr and sym_start are registered.
// They are loaded one clock ahead (div_cnt == DIV-2) so that the strobe
// coincides with the div_cnt == DIV-1 cycle in which the chip ends.
// ---------------------------------------------------------------------------
module dsss_spreader
    import dsss_pkg::*;
#(
    parameter int         DIV  = 8,
    parameter logic [5:0] SEED = DEFAULT_SEED
) (
    input  logic            clk,
    input  logic            rst,
    dsss_spreader_if.slave  io
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [7:0] DIV_PRE  = 8'(DIV - 2);

    state_t     state;
    state_t     state_next;
    logic [7:0] div_cnt;
    logic [5:0] pn_idx;       // index of the chip currently being sent
    logic       sym_bit;
    logic       pn_code;

    logic       chip_pre;     // next clock is the chip's strobe cycle
    logic       chip_end;     // strobe cycle: last clock of the chip
    logic       ready;
    logic       take;
    logic       pn_load;
    logic       pn_adv;

    logic       chip_out_q;
    logic       chip_stb_q;
    logic [7:0] pn_addr_q;
    logic       sym_start_q;
    logic       underrun_q;

    assign chip_pre = (state == RUN) && (div_cnt == DIV_PRE);
    assign chip_end = (state == RUN) && (div_cnt == DIV_LAST);
    assign take     = ready && io.din_valid;

    // -----------------------------------------------------------------------
    // PN generator
    // -----------------------------------------------------------------------
    pn_gen63 #(
        .SEED (SEED)
    ) u_pn (
        .clk  (clk),
        .rst  (rst),
        .load (pn_load),
        .adv  (pn_adv),
        .code (pn_code)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state, handshake and PN control
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        pn_load    = 1'b0;
        pn_adv     = 1'b0;

        unique case (state)
            IDLE: begin
                ready = io.en;
                if (io.en && io.din_valid) begin
                    state_next = RUN;
                    pn_load    = 1'b1;
                end
            end

            RUN: begin
                if (chip_end) begin
                    if (pn_idx == PN_LAST_IDX) begin
                        // Symbol boundary: restart the code from SEED so a
                        // receiver stays aligned even across data gaps.
                        pn_load = 1'b1;
                        ready   = io.en;
                        if (!io.en) begin
                            state_next = IDLE;
                        end
                    end else begin
                        pn_adv = 1'b1;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Divider, chip index, symbol bit, underrun and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= 8'd0;
            pn_idx      <= 6'd0;
            sym_bit     <= 1'b0;
            underrun_q  <= 1'b0;
            chip_out_q  <= 1'b0;
            chip_stb_q  <= 1'b0;
            pn_addr_q   <= 8'd0;
            sym_start_q <= 1'b0;
        end else begin
            chip_stb_q  <= chip_pre;
            sym_start_q <= chip_pre && (pn_idx == 6'd0);

            // chip_out / pn_addr only change with a strobe, so they hold
            // their last values while idle.
            if (chip_pre) begin
                chip_out_q <= sym_bit ^ pn_code;
                pn_addr_q  <= {2'b00, pn_idx};
            end

            if (state == IDLE) begin
                div_cnt <= 8'd0;
                pn_idx  <= 6'd0;
                if (take) begin
                    sym_bit <= io.din;
                end
                if (!io.en) begin
                    underrun_q <= 1'b0;
                end
            end else if (chip_end) begin
                div_cnt <= 8'd0;
                if (pn_idx == PN_LAST_IDX) begin
                    pn_idx <= 6'd0;
                    if (take) begin
                        sym_bit <= io.din;
                    end else if (io.en) begin
                        // No data at the boundary: keep transmitting the raw
                        // code rather than dropping lock.
                        sym_bit    <= 1'b0;
                        underrun_q <= 1'b1;
                    end
                end else begin
                    pn_idx <= pn_idx + 6'd1;
                end
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    // din_ready is combinational from en; it is masked during reset so that
    // every output reads 0 while rst is held.
    assign io.din_ready = ready && !rst;
    assign io.chip_out  = chip_out_q;
    assign io.chip_stb  = chip_stb_q;
    assign io.pn_addr   = pn_addr_q;
    assign io.sym_start = sym_start_q;
    assign io.underrun  = underrun_q;
    assign io.busy      = (state == RUN);

endmodule

// File: tb/tb_dsss_spreader.sv
// ---------------------------------------------------------------------------
// tb_dsss_spreader -- directed bench for dsss_spreader.
// Two instances: DIV=8 (main scenarios) and DIV=2 (fast-chip scenario).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dsss_spreader;

    logic clk;
    logic rst;
    int   cyc = 0;

    dsss_spreader_if if8 ();
    dsss_spreader_if if2 ();

    dsss_spreader #(.DIV(8), .SEED(6'b111111)) dut8 (
        .clk (clk),
        .rst (rst),
        .io  (if8)
    );

    dsss_spreader #(.DIV(2), .SEED(6'b111111)) dut2 (
        .clk (clk),
        .rst (rst),
        .io  (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected raw PN sequence, chip k in bit k.
    logic [62:0] pn;

    // Strobe capture log (shared by both instances, appended in order).
    logic       cap_chip  [0:1023];
    logic [7:0] cap_addr  [0:1023];
    logic       cap_start [0:1023];
    logic       cap_rdy   [0:1023];
    int         cap_cyc   [0:1023];
    int         cap_n = 0;

    int rdy_hits, rdy_stray, start_stray, busy_low, stb_double, timeouts;

    // m-sequence by its recurrence a[n] = a[n-6] ^ a[n-5], all-ones seed.
    function automatic logic [62:0] pn_model();
        logic [62:0] a;
        a = '0;
        for (int i = 0; i < 6; i++) a[i] = 1'b1;
        for (int i = 6; i < 63; i++) a[i] = a[i-6] ^ a[i-5];
        return a;
    endfunction

    function automatic logic [13:0] outs(input bit sel);
        if (sel)
            return {if2.din_ready, if2.chip_out, if2.chip_stb, if2.pn_addr,
                    if2.sym_start, if2.underrun, if2.busy};
        return {if8.din_ready, if8.chip_out, if8.chip_stb, if8.pn_addr,
                if8.sym_start, if8.underrun, if8.busy};
    endfunction

    task automatic clear_flags();
        rdy_hits = 0; rdy_stray = 0; start_stray = 0;
        busy_low = 0; stb_double = 0; timeouts = 0;
    endtask

    // Record the next n strobes of one instance (sel=1: DIV=2), bounded.
    task automatic collect(input bit sel, input int n);
        int   got;
        int   waited;
        int   budget;
        bit   prev_stb;
        logic s_stb, s_chip, s_start, s_rdy, s_busy;
        logic [7:0] s_addr;
        got = 0; waited = 0; prev_stb = 1'b0;
        budget = n * (sel ? 3 : 9) + 20;
        while (got < n && waited < budget) begin
            @(negedge clk);
            waited++;
            s_stb   = sel ? if2.chip_stb  : if8.chip_stb;
            s_chip  = sel ? if2.chip_out  : if8.chip_out;
            s_start = sel ? if2.sym_start : if8.sym_start;
            s_rdy   = sel ? if2.din_ready : if8.din_ready;
            s_busy  = sel ? if2.busy      : if8.busy;
            s_addr  = sel ? if2.pn_addr   : if8.pn_addr;
            if (s_rdy) rdy_hits++;
            if (s_rdy && !(s_stb && s_addr == 8'd62)) rdy_stray++;
            if (s_start && !(s_stb && s_addr == 8'd0)) start_stray++;
            if (!s_busy) busy_low++;
            if (s_stb && prev_stb) stb_double++;
            prev_stb = s_stb;
            if (s_stb) begin
                cap_chip[cap_n]  = s_chip;
                cap_addr[cap_n]  = s_addr;
                cap_start[cap_n] = s_start;
                cap_rdy[cap_n]   = s_rdy;
                cap_cyc[cap_n]   = cyc;
                cap_n++;
                got++;
            end
        end
        if (got < n) timeouts++;
    endtask

    int base1, base2;

    // -----------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        if8.en = 1'b1; if8.din = 1'b0; if8.din_valid = 1'b1;
        if2.en = 1'b1; if2.din = 1'b0; if2.din_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs(0) !== 14'd0) $display("FAIL reset_outs_div8: got %b expected 0", outs(0));
        else n_pass++;
        n_checks++;
        if (outs(1) !== 14'd0) $display("FAIL reset_outs_div2: got %b expected 0", outs(1));
        else n_pass++;

        rst = 1'b0;
        if8.en = 1'b0; if8.din_valid = 1'b0;
        if2.en = 1'b0; if2.din_valid = 1'b0;
        #1;
        n_checks++;
        if ({if8.din_ready, if8.busy} !== 2'b00)
            $display("FAIL idle_en0: got %b expected 00", {if8.din_ready, if8.busy});
        else n_pass++;
        @(negedge clk);
        if8.en = 1'b1;
        #1;
        n_checks++;
        if ({if8.din_ready, if8.busy} !== 2'b10)
            $display("FAIL idle_ready_follows_en: got %b expected 10", {if8.din_ready, if8.busy});
        else n_pass++;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_first_symbol();
        int t0, err_t, err_a, err_c, ones, starts;
        logic [6:0] first7;
        @(negedge clk);
        if8.en = 1'b1; if8.din = 1'b0; if8.din_valid = 1'b1;
        #1;
        n_checks++;
        if (if8.din_ready !== 1'b1) $display("FAIL first_xfer_ready: got %b expected 1", if8.din_ready);
        else n_pass++;
        t0 = cyc;
        clear_flags();
        base1 = cap_n;
        @(negedge clk);
        if8.din = 1'b1;
        collect(0, 63);

        err_t = 0; err_a = 0; err_c = 0; ones = 0; starts = 0;
        for (int k = 0; k < 63; k++) begin
            if (cap_cyc[base1+k] != t0 + 8*(k+1)) err_t++;
            if (cap_addr[base1+k] !== 8'(k)) err_a++;
            if (cap_chip[base1+k] !== pn[k]) err_c++;
            if (cap_chip[base1+k] === 1'b1) ones++;
            if (cap_start[base1+k] === 1'b1) starts++;
        end
        for (int k = 0; k < 7; k++) first7[6-k] = cap_chip[base1+k];

        n_checks++;
        if (timeouts !== 0) $display("FAIL sym1_timeout: got %0d expected 0", timeouts);
        else n_pass++;
        n_checks++;
        if (err_t !== 0) $display("FAIL sym1_strobe_timing: got %0d bad expected 0 (first at %0d, want %0d)", err_t, cap_cyc[base1], t0 + 8);
        else n_pass++;
        n_checks++;
        if (first7 !== 7'b1111110) $display("FAIL sym1_first7: got %b expected 1111110", first7);
        else n_pass++;
        n_checks++;
        if (ones !== 32) $display("FAIL sym1_ones: got %0d expected 32", ones);
        else n_pass++;
        n_checks++;
        if (err_a !== 0) $display("FAIL sym1_pn_addr: got %0d bad expected 0", err_a);
        else n_pass++;
        n_checks++;
        if (err_c !== 0) $display("FAIL sym1_chips_vs_pn: got %0d bad expected 0", err_c);
        else n_pass++;
        n_checks++;
        if ({starts, cap_start[base1], start_stray} !== {32'd1, 1'b1, 32'd0})
            $display("FAIL sym1_sym_start: got count %0d first %b stray %0d expected 1 1 0", starts, cap_start[base1], start_stray);
        else n_pass++;
        n_checks++;
        if (stb_double !== 0) $display("FAIL sym1_stb_width: got %0d doubles expected 0", stb_double);
        else n_pass++;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        int err_inv, err_pn;
        n_checks++;
        if (cap_rdy[base1+62] !== 1'b1) $display("FAIL sym1_end_ready: got %b expected 1", cap_rdy[base1+62]);
        else n_pass++;
        clear_flags();
        base2 = cap_n;
        @(negedge clk);
        if8.din = 1'b0;
        collect(0, 63);
        @(negedge clk);
        if8.din = 1'b1;
        collect(0, 63);

        err_inv = 0; err_pn = 0;
        for (int k = 0; k < 63; k++) begin
            if (cap_chip[base2+k] !== ~cap_chip[base2+63+k]) err_inv++;
            if (cap_chip[base2+k] !== ~pn[k]) err_pn++;
        end
        n_checks++;
        if (timeouts !== 0) $display("FAIL b2b_timeout: got %0d expected 0", timeouts);
        else n_pass++;
        n_checks++;
        if (err_inv !== 0) $display("FAIL b2b_inverse: got %0d bad expected 0", err_inv);
        else n_pass++;
        n_checks++;
        if (err_pn !== 0) $display("FAIL b2b_din1_vs_pn: got %0d bad expected 0", err_pn);
        else n_pass++;
        n_checks++;
        if (cap_cyc[base2] - cap_cyc[base1+62] !== 8)
            $display("FAIL b2b_no_gap: got %0d expected 8", cap_cyc[base2] - cap_cyc[base1+62]);
        else n_pass++;
        n_checks++;
        if ({rdy_hits, rdy_stray} !== {32'd2, 32'd0})
            $display("FAIL b2b_ready_pulses: got hits %0d stray %0d expected 2 0", rdy_hits, rdy_stray);
        else n_pass++;
        n_checks++;
        if (cap_cyc[base2+125] - cap_cyc[base2+62] !== 504)
            $display("FAIL b2b_ready_period: got %0d expected 504", cap_cyc[base2+125] - cap_cyc[base2+62]);
        else n_pass++;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_underrun();
        int b, err_4, err_5;
        n_checks++;
        if (if8.underrun !== 1'b0) $display("FAIL underrun_pre: got %b expected 0", if8.underrun);
        else n_pass++;
        clear_flags();
        b = cap_n;
        collect(0, 20);
        if8.din_valid = 1'b0;
        collect(0, 43);
        n_checks++;
        if (if8.underrun !== 1'b0) $display("FAIL underrun_before_boundary: got %b expected 0", if8.underrun);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({if8.underrun, if8.busy} !== 2'b11)
            $display("FAIL underrun_set: got underrun,busy %b expected 11", {if8.underrun, if8.busy});
        else n_pass++;
        collect(0, 63);
        err_4 = 0; err_5 = 0;
        for (int k = 0; k < 63; k++) begin
            if (cap_chip[b+k] !== ~pn[k]) err_4++;
            if (cap_chip[b+63+k] !== pn[k]) err_5++;
        end
        n_checks++;
        if (timeouts !== 0) $display("FAIL underrun_timeout: got %0d expected 0", timeouts);
        else n_pass++;
        n_checks++;
        if (err_4 !== 0) $display("FAIL underrun_sym4_chips: got %0d bad expected 0", err_4);
        else n_pass++;
        n_checks++;
        if (err_5 !== 0) $display("FAIL underrun_raw_pn: got %0d bad expected 0", err_5);
        else n_pass++;
        n_checks++;
        if ({busy_low, if8.underrun} !== {32'd0, 1'b1})
            $display("FAIL underrun_busy_sticky: got busy_low %0d underrun %b expected 0 1", busy_low, if8.underrun);
        else n_pass++;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_en_drop();
        int b, err_a, err_c, stbs;
        clear_flags();
        b = cap_n;
        collect(0, 31);
        n_checks++;
        if (cap_addr[b+30] !== 8'd30) $display("FAIL endrop_at30: got %0d expected 30", cap_addr[b+30]);
        else n_pass++;
        if8.en = 1'b0;
        collect(0, 32);
        err_a = 0; err_c = 0;
        for (int k = 31; k < 63; k++) begin
            if (cap_addr[b+k] !== 8'(k)) err_a++;
            if (cap_chip[b+k] !== pn[k]) err_c++;
        end
        n_checks++;
        if ({timeouts, err_a, err_c} !== 96'd0)
            $display("FAIL endrop_tail: got timeouts %0d addr_bad %0d chip_bad %0d expected 0 0 0", timeouts, err_a, err_c);
        else n_pass++;
        n_checks++;
        if ({cap_rdy[b+62], rdy_hits} !== {1'b0, 32'd0})
            $display("FAIL endrop_ready: got %b hits %0d expected 0 0", cap_rdy[b+62], rdy_hits);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({if8.busy, if8.chip_stb, if8.din_ready} !== 3'b000)
            $display("FAIL endrop_idle: got busy,stb,ready %b expected 000", {if8.busy, if8.chip_stb, if8.din_ready});
        else n_pass++;
        stbs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if8.chip_stb) stbs++;
        end
        n_checks++;
        if (stbs !== 0) $display("FAIL endrop_no_strobes: got %0d expected 0", stbs);
        else n_pass++;
        n_checks++;
        if (if8.underrun !== 1'b0) $display("FAIL endrop_underrun_clear: got %b expected 0", if8.underrun);
        else n_pass++;
        n_checks++;
        if ({if8.pn_addr, if8.chip_out} !== {8'd62, pn[62]})
            $display("FAIL endrop_hold: got addr %0d chip %b expected 62 %b", if8.pn_addr, if8.chip_out, pn[62]);
        else n_pass++;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid();
        int b, t1, stbs, err_a;
        logic [6:0] first7;
        @(negedge clk);
        if8.en = 1'b1; if8.din = 1'b1; if8.din_valid = 1'b1;
        @(negedge clk);
        clear_flags();
        b = cap_n;
        collect(0, 41);
        n_checks++;
        if ({timeouts, cap_addr[b+40]} !== {32'd0, 8'd40})
            $display("FAIL rstmid_reach40: got timeouts %0d addr %0d expected 0 40", timeouts, cap_addr[b+40]);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (outs(0) !== 14'd0) $display("FAIL rstmid_outs: got %b expected 0", outs(0));
        else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        if8.en = 1'b0; if8.din_valid = 1'b0;
        stbs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (if8.chip_stb || if8.busy) stbs++;
        end
        n_checks++;
        if (stbs !== 0) $display("FAIL rstmid_quiet: got %0d active cycles expected 0", stbs);
        else n_pass++;

        if8.en = 1'b1; if8.din = 1'b0; if8.din_valid = 1'b1;
        #1;
        t1 = cyc;
        @(negedge clk);
        if8.din_valid = 1'b0;
        clear_flags();
        b = cap_n;
        collect(0, 7);
        err_a = 0;
        for (int k = 0; k < 7; k++) begin
            first7[6-k] = cap_chip[b+k];
            if (cap_addr[b+k] !== 8'(k)) err_a++;
        end
        n_checks++;
        if ({timeouts, err_a} !== 64'd0)
            $display("FAIL rstmid_restart_addr: got timeouts %0d addr_bad %0d expected 0 0", timeouts, err_a);
        else n_pass++;
        n_checks++;
        if (first7 !== 7'b1111110) $display("FAIL rstmid_first7: got %b expected 1111110", first7);
        else n_pass++;
        n_checks++;
        if ({cap_cyc[b] - t1, cap_start[b]} !== {32'd8, 1'b1})
            $display("FAIL rstmid_latency: got %0d start %b expected 8 1", cap_cyc[b] - t1, cap_start[b]);
        else n_pass++;
        if8.en = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_div2();
        int b, t0, err_t, err_c;
        @(negedge clk);
        if2.en = 1'b1; if2.din = 1'b1; if2.din_valid = 1'b1;
        #1;
        n_checks++;
        if (if2.din_ready !== 1'b1) $display("FAIL div2_xfer_ready: got %b expected 1", if2.din_ready);
        else n_pass++;
        t0 = cyc;
        @(negedge clk);
        if2.din = 1'b0;
        clear_flags();
        b = cap_n;
        collect(1, 126);
        err_t = 0; err_c = 0;
        for (int k = 0; k < 126; k++) begin
            if (cap_cyc[b+k] != t0 + 2*(k+1)) err_t++;
            if (cap_chip[b+k] !== (pn[k % 63] ^ (k < 63))) err_c++;
        end
        n_checks++;
        if ({timeouts, err_t} !== 64'd0)
            $display("FAIL div2_timing: got timeouts %0d bad %0d expected 0 0", timeouts, err_t);
        else n_pass++;
        n_checks++;
        if (cap_cyc[b+63] - cap_cyc[b] !== 126)
            $display("FAIL div2_symbol_len: got %0d expected 126", cap_cyc[b+63] - cap_cyc[b]);
        else n_pass++;
        n_checks++;
        if (err_c !== 0) $display("FAIL div2_chips: got %0d bad expected 0", err_c);
        else n_pass++;
        n_checks++;
        if ({rdy_hits, rdy_stray, cap_rdy[b+62], cap_rdy[b+125]} !== {32'd2, 32'd0, 2'b11})
            $display("FAIL div2_ready: got hits %0d stray %0d at62 %b at125 %b expected 2 0 1 1",
                     rdy_hits, rdy_stray, cap_rdy[b+62], cap_rdy[b+125]);
        else n_pass++;
        n_checks++;
        if ({stb_double, start_stray} !== 64'd0)
            $display("FAIL div2_strobes: got doubles %0d start_stray %0d expected 0 0", stb_double, start_stray);
        else n_pass++;
        if2.en = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    initial begin
        pn = pn_model();
        rst = 1'b1;
        if8.en = 1'b0; if8.din = 1'b0; if8.din_valid = 1'b0;
        if2.en = 1'b0; if2.din = 1'b0; if2.din_valid = 1'b0;
        clear_flags();

        test_reset();
        test_first_symbol();
        test_back_to_back();
        test_underrun();
        test_en_drop();
        test_reset_mid();
        test_div2();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
